// File: rtl/program_memory_loader_if.sv
// Byte-stream input and program-memory write bus of the program memory loader.
// master: the loader; slave: the host link and memory side.
interface program_memory_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            ByteIn;
  logic                  ByteValid;
  logic                  ByteReady;
  logic                  MemWrite;
  logic [DATA_WIDTH-1:0] MemAddress;
  logic [DATA_WIDTH-1:0] MemWriteData;

  modport master (
    input  ByteIn, ByteValid,
    output ByteReady, MemWrite, MemAddress, MemWriteData
  );

  modport slave (
    output ByteIn, ByteValid,
    input  ByteReady, MemWrite, MemAddress, MemWriteData
  );
endinterface

// File: rtl/program_memory_loader.sv
// Assembles a big-endian byte stream into 32-bit words and writes them to program memory.
// Optional trailing checksum byte is enabled by the macro LOADER_CHECKSUM_EN.
module program_memory_loader #(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h00400000,
  localparam int                   CW           = $clog2(MEMORY_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Start,
  input  logic [CW-1:0]            WordCount,
  program_memory_loader_if.master  bus,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Error,
  output logic [CW-1:0]            WordsWritten
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;

  localparam logic [CW-1:0] DEPTH_W = CW'(MEMORY_DEPTH);

  logic [2:0]             state_q, state_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-9:0]  asm_q, asm_d;
  logic [CW-1:0]          words_q, words_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   busy_q, busy_d;
  logic                   byte_ready_q, byte_ready_d;
  logic                   mem_write_q, mem_write_d;
  logic [DATA_WIDTH-1:0]  mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]  mem_write_data_q, mem_write_data_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             acc_q, acc_d;
  logic [7:0]             check_sum;
`endif

  logic          byte_xfer;
  logic [CW-1:0] words_inc;

  assign byte_xfer = bus.ByteValid && byte_ready_q;
  assign words_inc = words_q + CW'(1);
`ifdef LOADER_CHECKSUM_EN
  assign check_sum = acc_q + bus.ByteIn;
`endif

  always_comb begin
    state_d          = state_q;
    byte_cnt_d       = byte_cnt_q;
    asm_d            = asm_q;
    words_d          = words_q;
    count_d          = count_q;
    busy_d           = busy_q;
    byte_ready_d     = byte_ready_q;
    mem_write_d      = 1'b0;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    done_d           = 1'b0;
    error_d          = error_q;
`ifdef LOADER_CHECKSUM_EN
    acc_d            = acc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (WordCount == '0 || WordCount > DEPTH_W) begin
            error_d = 1'b1;
          end else begin
            count_d      = WordCount;
            error_d      = 1'b0;
            words_d      = '0;
            byte_cnt_d   = '0;
            asm_d        = '0;
            busy_d       = 1'b1;
            byte_ready_d = 1'b1;
            state_d      = S_COLLECT;
`ifdef LOADER_CHECKSUM_EN
            acc_d        = '0;
`endif
          end
        end
      end

      S_COLLECT: begin
        if (byte_xfer) begin
          // Earlier bytes move up, so the first byte ends in bits 31:24.
          asm_d      = {asm_q[DATA_WIDTH-17:0], bus.ByteIn};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          acc_d      = check_sum;
`endif
          if (byte_cnt_q == 2'd3) begin
            state_d          = S_WRITE;
            byte_ready_d     = 1'b0;
            mem_write_d      = 1'b1;
            mem_address_d    = BASE_ADDRESS + (DATA_WIDTH'(words_q) << 2);
            mem_write_data_d = {asm_q, bus.ByteIn};
          end
        end
      end

      S_WRITE: begin
        words_d = words_inc;
        if (words_inc == count_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d      = S_CHECK;
          byte_ready_d = 1'b1;
`else
          state_d      = S_DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
`endif
        end else begin
          state_d      = S_COLLECT;
          byte_ready_d = 1'b1;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (byte_xfer) begin
          // Words already written stay in memory even on a bad checksum.
          if (check_sum != 8'd0) error_d = 1'b1;
          byte_ready_d = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          state_d      = S_DONE;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d      = S_IDLE;
        busy_d       = 1'b0;
        byte_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      byte_cnt_q       <= '0;
      asm_q            <= '0;
      words_q          <= '0;
      count_q          <= '0;
      busy_q           <= 1'b0;
      byte_ready_q     <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc_q            <= '0;
`endif
    end else begin
      state_q          <= state_d;
      byte_cnt_q       <= byte_cnt_d;
      asm_q            <= asm_d;
      words_q          <= words_d;
      count_q          <= count_d;
      busy_q           <= busy_d;
      byte_ready_q     <= byte_ready_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      done_q           <= done_d;
      error_q          <= error_d;
`ifdef LOADER_CHECKSUM_EN
      acc_q            <= acc_d;
`endif
    end
  end

  assign bus.ByteReady    = byte_ready_q;
  assign bus.MemWrite     = mem_write_q;
  assign bus.MemAddress   = mem_address_q;
  assign bus.MemWriteData = mem_write_data_q;
  assign Busy             = busy_q;
  assign Done             = done_q;
  assign Error            = error_q;
  assign WordsWritten     = words_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed testbench for program_memory_loader; define LOADER_CHECKSUM_EN to cover the checksum path.
module tb_program_memory_loader;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          Start = 1'b0;
  logic [CW-1:0] WordCount = '0;
  logic          Busy, Done, Error;
  logic [CW-1:0] WordsWritten;

  program_memory_loader_if #(.DATA_WIDTH(32)) bus ();

  program_memory_loader dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
    .WordCount    (WordCount),
    .bus          (bus.master),
    .Busy         (Busy),
    .Done         (Done),
    .Error        (Error),
    .WordsWritten (WordsWritten)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          nwr = 0;
  int          ndone = 0;
  int          done_cyc = 0;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_cyc  [0:63];
  logic [7:0]  sum_acc = 8'd0;
  int          s_cyc = 0;
  int          w0, d0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write and Done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.MemWrite && nwr < 64) begin
      wr_addr[nwr] <= bus.MemAddress;
      wr_data[nwr] <= bus.MemWriteData;
      wr_cyc[nwr]  <= cyc;
      nwr          <= nwr + 1;
      $display("write: addr=%08h data=%08h cycle=%0d", bus.MemAddress, bus.MemWriteData, cyc);
    end
    if (Done) begin
      ndone    <= ndone + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [CW-1:0] count);
    Start     = 1'b1;
    WordCount = count;
    sum_acc   = 8'd0;
    @(posedge clk); #1;
    Start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic push(input logic [7:0] b);
    int t;
    bus.ByteIn    = b;
    bus.ByteValid = 1'b1;
    t = 0;
    while (!bus.ByteReady && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.ByteReady) begin
      check("byte_ready_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      sum_acc = sum_acc + b;
    end
  endtask

  task automatic end_load();
`ifdef LOADER_CHECKSUM_EN
    push(8'd0 - sum_acc);
`endif
    bus.ByteValid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (Done) begin
        @(posedge clk); #1;
        return;
      end
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.ByteIn    = 8'h00;
    bus.ByteValid = 1'b0;

    // Reset state
    idle(2);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_ready", 32'(bus.ByteReady), 32'd0);
    check("rst_words", 32'(WordsWritten), 32'd0);
    reset = 1'b1;
    idle(2);

    // Two-word load, ByteValid held high
    w0 = nwr; d0 = ndone;
    do_start(6'd2);
    check("t1_busy", 32'(Busy), 32'd1);
    check("t1_ready", 32'(bus.ByteReady), 32'd1);
    push(8'h20); push(8'h08); push(8'h00); push(8'h05);
    push(8'h21); push(8'h09); push(8'hFF); push(8'hFF);
    end_load();
    wait_done();
    check("t1_nwr", 32'(nwr - w0), 32'd2);
    check("t1_addr0", wr_addr[w0], 32'h00400000);
    check("t1_data0", wr_data[w0], 32'h20080005);
    check("t1_addr1", wr_addr[w0+1], 32'h00400004);
    check("t1_data1", wr_data[w0+1], 32'h2109FFFF);
    check("t1_latency", 32'(wr_cyc[w0] - s_cyc), 32'd4);
    check("t1_spacing", 32'(wr_cyc[w0+1] - wr_cyc[w0]), 32'd5);
`ifndef LOADER_CHECKSUM_EN
    check("t1_done_lat", 32'(done_cyc - wr_cyc[w0+1]), 32'd1);
`endif
    check("t1_ndone", 32'(ndone - d0), 32'd1);
    check("t1_words", 32'(WordsWritten), 32'd2);
    check("t1_busy_end", 32'(Busy), 32'd0);
    check("t1_error", 32'(Error), 32'd0);

    // Same load with a 3-cycle ByteValid gap between bytes 2 and 3
    w0 = nwr; d0 = ndone;
    do_start(6'd2);
    push(8'h20); push(8'h08);
    bus.ByteValid = 1'b0;
    idle(3);
    push(8'h00); push(8'h05);
    push(8'h21); push(8'h09); push(8'hFF); push(8'hFF);
    end_load();
    wait_done();
    check("t2_nwr", 32'(nwr - w0), 32'd2);
    check("t2_data0", wr_data[w0], 32'h20080005);
    check("t2_data1", wr_data[w0+1], 32'h2109FFFF);
    check("t2_addr1", wr_addr[w0+1], 32'h00400004);
    check("t2_latency", 32'(wr_cyc[w0] - s_cyc), 32'd7);
    check("t2_ndone", 32'(ndone - d0), 32'd1);

    // Illegal word counts
    w0 = nwr; d0 = ndone;
    do_start(6'd0);
    check("t3_err0", 32'(Error), 32'd1);
    check("t3_busy0", 32'(Busy), 32'd0);
    idle(2);
    do_start(6'd33);
    check("t3_err33", 32'(Error), 32'd1);
    idle(5);
    check("t3_busy33", 32'(Busy), 32'd0);
    check("t3_ready", 32'(bus.ByteReady), 32'd0);
    check("t3_nwr", 32'(nwr - w0), 32'd0);
    check("t3_ndone", 32'(ndone - d0), 32'd0);

    // Legal start clears Error; reset mid-load discards the partial word
    do_start(6'd3);
    check("t4_err_clr", 32'(Error), 32'd0);
    push(8'h11); push(8'h22);
    bus.ByteValid = 1'b0;
    reset = 1'b0;
    #1;
    check("t4_rst_busy", 32'(Busy), 32'd0);
    check("t4_rst_ready", 32'(bus.ByteReady), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);
    w0 = nwr; d0 = ndone;
    do_start(6'd1);
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    end_load();
    wait_done();
    check("t4_nwr", 32'(nwr - w0), 32'd1);
    check("t4_addr", wr_addr[w0], 32'h00400000);
    check("t4_data", wr_data[w0], 32'hAABBCCDD);
    check("t4_words", 32'(WordsWritten), 32'd1);
    check("t4_ndone", 32'(ndone - d0), 32'd1);

    // Start while Busy is ignored
    w0 = nwr; d0 = ndone;
    do_start(6'd1);
    push(8'h5A); push(8'hA5);
    Start = 1'b1; WordCount = 6'd2;
    push(8'h3C);
    Start = 1'b0;
    push(8'hC3);
    end_load();
    wait_done();
    idle(3);
    check("t5_nwr", 32'(nwr - w0), 32'd1);
    check("t5_data", wr_data[w0], 32'h5AA53CC3);
    check("t5_ndone", 32'(ndone - d0), 32'd1);
    check("t5_words", 32'(WordsWritten), 32'd1);
    check("t5_busy", 32'(Busy), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum
    w0 = nwr; d0 = ndone;
    do_start(6'd1);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    push(8'hF6);
    bus.ByteValid = 1'b0;
    wait_done();
    check("c1_error", 32'(Error), 32'd0);
    check("c1_ndone", 32'(ndone - d0), 32'd1);
    check("c1_data", wr_data[w0], 32'h01020304);

    // Bad checksum: Error set, word still written
    w0 = nwr; d0 = ndone;
    do_start(6'd1);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    push(8'hF7);
    bus.ByteValid = 1'b0;
    wait_done();
    check("c2_error", 32'(Error), 32'd1);
    check("c2_ndone", 32'(ndone - d0), 32'd1);
    check("c2_nwr", 32'(nwr - w0), 32'd1);
    check("c2_data", wr_data[w0], 32'h01020304);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
